// File: rtl/mul_share_arbiter.sv
// Round-robin front end that lets two requesters share one sequential multiplier.
// Each grant latches operands, starts the multiplier, waits for done or a timeout, and returns one result pulse.
module mul_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rerr0,
    output logic             rerr1,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state, state_next;
    logic             last, owner, err;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] res;
    logic             pick0, pick1, done_ok, timed_out;

    always_comb begin
        pick0      = req0 && (!req1 || last);
        pick1      = req1 && (!req0 || !last);
        // cnt is 0 only in the first WAIT cycle, which blocks a stale done.
        done_ok    = (state == WAIT) && mul_done && (cnt != '0);
        timed_out  = (state == WAIT) && !done_ok && (cnt == CNT_LAST);
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rvalid0    = 1'b0;
        rvalid1    = 1'b0;
        rdata0     = '0;
        rdata1     = '0;
        rerr0      = 1'b0;
        rerr1      = 1'b0;
        mul_start  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick0 || pick1) begin
                    state_next = START;
                    gnt0       = pick0 && rst;
                    gnt1       = pick1 && rst;
                end
            end
            START: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (done_ok || timed_out) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                if (owner) begin
                    rvalid1 = 1'b1;
                    rdata1  = res;
                    rerr1   = err;
                end else begin
                    rvalid0 = 1'b1;
                    rdata0  = res;
                    rerr0   = err;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        owner <= pick1;
                        last  <= pick1;
                        mul_a <= pick1 ? a1 : a0;
                        mul_b <= pick1 ? b1 : b0;
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (done_ok) begin
                        res <= mul_result;
                        err <= 1'b0;
                    end else if (timed_out) begin
                        res <= '0;
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural multiplier stub
// (configurable latency, stale done, never-done).
module tb_mul_share_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, mul_start, busy;
    logic [W-1:0] rdata0, rdata1, mul_a, mul_b;
    logic [W-1:0] mul_result = '0;
    logic         mul_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mul_share_arbiter #(.WIDTH(W), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rerr0(rerr0), .rerr1(rerr1),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: done rises 'lat' edges after the start edge and is held until the next start.
    int scnt  = 0;
    int lat   = 1;
    bit stale = 1'b0;
    bit never = 1'b0;
    always @(posedge clk) begin
        if (mul_start) begin
            scnt <= 1;
            if (!stale) mul_done <= 1'b0;
        end else if (scnt != 0) begin
            scnt <= scnt + 1;
            if (scnt == 1) mul_done <= 1'b0;
            if (scnt == lat) begin
                scnt <= 0;
                if (!never) begin
                    mul_done   <= 1'b1;
                    mul_result <= mul_a * mul_b;
                end
            end
        end
    end

    typedef struct {
        bit           sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_d;
        int           lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_rv(input bit sel, output int at);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (rvalid0 || rvalid1) got = 1'b1;
        end
        at = cyc;
        check("rvalid_seen", got, 1);
        check("rvalid_owner", sel ? rvalid1 : rvalid0, 1);
        check("rvalid_other", sel ? rvalid0 : rvalid1, 0);
        check("rdata_other", sel ? rdata0 : rdata1, 0);
    endtask

    // One isolated transaction from an idle arbiter; grant expected in the first cycle.
    task automatic run_txn(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_d, input bit exp_e, input int exp_lat);
        int t, at;
        @(negedge clk);
        if (sel) begin req1 = 1'b1; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; end
        #1;
        check("gnt_owner", sel ? gnt1 : gnt0, 1);
        check("gnt_other", sel ? gnt0 : gnt1, 0);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("mul_start", mul_start, 1);
        check("mul_a", mul_a, a);
        check("mul_b", mul_b, b);
        check("busy", busy, 1);
        wait_rv(sel, at);
        check("latency", at - t, exp_lat);
        check("rdata", sel ? rdata1 : rdata0, exp_d);
        check("rerr", sel ? rerr1 : rerr0, exp_e);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        int t, at;
        bit seen;

        vecs[0] = '{sel: 1'b0, a: 8'd5,   b: 8'd3,   exp_d: 8'd15,  lat: 1};
        vecs[1] = '{sel: 1'b1, a: 8'd0,   b: 8'd50,  exp_d: 8'd0,   lat: 1};
        vecs[2] = '{sel: 1'b0, a: 8'd255, b: 8'd255, exp_d: 8'd1,   lat: 3};
        vecs[3] = '{sel: 1'b1, a: 8'd16,  b: 8'd16,  exp_d: 8'd0,   lat: 2};
        vecs[4] = '{sel: 1'b0, a: 8'd13,  b: 8'd11,  exp_d: 8'd143, lat: 1};
        vecs[5] = '{sel: 1'b1, a: 8'd200, b: 8'd3,   exp_d: 8'd88,  lat: 4};

        // Reset state, with a request pending to confirm grants are held off.
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rdata0", rdata0, 0);
        req0 = 1'b0;
        @(negedge clk); rst = 1'b1;

        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            run_txn(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_d, 1'b0, 3 + vecs[i].lat);
        end

        // Stale done: previous result (88) and done still high during the first WAIT cycle.
        stale = 1'b1; lat = 2;
        run_txn(1'b0, 8'd6, 8'd7, 8'd42, 1'b0, 5);
        stale = 1'b0;

        // Timeout, then a normal follow-up.
        never = 1'b1; lat = 1;
        run_txn(1'b0, 8'd9, 8'd9, 8'd0, 1'b1, 34);
        never = 1'b0;
        run_txn(1'b1, 8'd3, 8'd4, 8'd12, 1'b0, 4);

        // Simultaneous requests after reset, then alternation.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; a0 = 8'd12;  b0 = 8'd10;
        req1 = 1'b1; a1 = 8'd255; b1 = 8'd2;
        #1;
        check("tie_gnt0", gnt0, 1);
        check("tie_gnt1", gnt1, 0);
        t = cyc;
        @(negedge clk); req0 = 1'b0;
        wait_rv(1'b0, at);
        check("tie_lat0", at - t, 4);
        check("tie_rdata0", rdata0, 120);
        @(negedge clk); #1;
        check("tie_gnt1_d2", gnt1, 1);
        req0 = 1'b1;
        wait_rv(1'b1, at);
        check("tie_rdata1", rdata1, 254);
        @(negedge clk); #1;
        check("alt_gnt0", gnt0, 1);
        check("alt_gnt1", gnt1, 0);
        @(negedge clk); req0 = 1'b0; req1 = 1'b0;
        wait_rv(1'b0, at);
        check("alt_rdata0", rdata0, 120);

        // Back-to-back on requester 1: 0x50 then 7x9, second grant at D+2.
        @(negedge clk);
        req1 = 1'b1; a1 = 8'd0; b1 = 8'd50;
        #1;
        check("b2b_gnt1a", gnt1, 1);
        @(negedge clk); a1 = 8'd7; b1 = 8'd9;
        wait_rv(1'b1, at);
        check("b2b_rdata1a", rdata1, 0);
        @(negedge clk); #1;
        check("b2b_gnt1b", gnt1, 1);
        @(negedge clk); req1 = 1'b0;
        wait_rv(1'b1, at);
        check("b2b_rdata1b", rdata1, 63);

        // Reset during WAIT abandons the operation.
        lat = 20;
        @(negedge clk);
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
        #1;
        check("abort_gnt0", gnt0, 1);
        @(negedge clk); req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_mul_a", mul_a, 0);
        check("abort_mul_b", mul_b, 0);
        check("abort_gnt0_off", gnt0, 0);
        check("abort_gnt1_off", gnt1, 0);
        check("abort_rvalid0", rvalid0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (rvalid0 || rvalid1 || busy) seen = 1'b1;
        end
        check("abort_no_rvalid", seen, 0);
        lat = 1;
        @(negedge clk);
        req0 = 1'b1; a0 = 8'd4; b0 = 8'd5;
        req1 = 1'b1; a1 = 8'd6; b1 = 8'd6;
        #1;
        check("post_rst_gnt0", gnt0, 1);
        check("post_rst_gnt1", gnt1, 0);
        @(negedge clk); req0 = 1'b0;
        wait_rv(1'b0, at);
        check("post_rst_rdata0", rdata0, 20);
        @(negedge clk); #1;
        check("post_rst_gnt1b", gnt1, 1);
        @(negedge clk); req1 = 1'b0;
        wait_rv(1'b1, at);
        check("post_rst_rdata1", rdata1, 36);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one `seq_unsigned_multiplier` instance between two requesters, for example the ALU execute path and an address-generation path. It sits between the requesters and the multiplier:
- a round-robin arbiter picks one pending request;
- it latches that request's operands and pulses the multiplier's `start`;
- it waits for `done`, with a timeout guard;
- it returns the low `WIDTH` bits of the product to the owning requester as a one-cycle valid pulse.

## Interface

Parameters:
- `WIDTH`, 8: operand and result width; must match the multiplier.
- `TIMEOUT`, 32: maximum WAIT cycles before the arbiter abandons the operation. Legal range is 2 to 255.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req0`, `req1`  in  1 each: request. The requester holds it high with stable operands until its `gnt` pulses.
- `a0`, `b0`, `a1`, `b1`  in  `WIDTH` each: operands of requester 0 and requester 1.
- `gnt0`, `gnt1`  out  1 each: one-cycle accept pulse. Operands are captured on the same edge.
- `rvalid0`, `rvalid1`  out  1 each: one-cycle result-valid pulse.
- `rdata0`, `rdata1`  out  `WIDTH` each: result. Valid only while the matching `rvalid` is high; 0 otherwise.
- `rerr0`, `rerr1`  out  1 each: timeout flag. Valid only with the matching `rvalid`.
- `mul_start`  out  1: start pulse to the multiplier.
- `mul_a`, `mul_b`  out  `WIDTH` each: latched operands. Held stable from START through the end of WAIT.
- `mul_result`  in  `WIDTH`: multiplier result, low `WIDTH` bits of the product.
- `mul_done`  in  1: multiplier completion.
- `busy`  out  1: high in every state except IDLE.

## Operation

- The FSM has four states: IDLE, START, WAIT, RESP.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not served last, using the `last` pointer.
  - On a grant: pulse the owner's `gnt` combinationally in this cycle. On the edge, latch `mul_a`/`mul_b` from the owner's operands, store `owner`, set `last = owner`, and go to START.
- **START:** `mul_start = 1` for exactly this one cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:**
  - `mul_done` is ignored in the first WAIT cycle, so a stale `done` left over from the previous operation is never taken.
  - From the second WAIT cycle on, `mul_done = 1` captures `mul_result` into the result register, clears `err`, and moves to RESP.
  - The counter increments every WAIT cycle. When it reaches `TIMEOUT - 1` without an accepted `done`, the arbiter sets the result register to 0, sets `err = 1`, and moves to RESP.
  - If `done` is accepted in the same cycle the timeout is hit, `done` wins and `err = 0`.
- **RESP:**
  - Drive the owner's `rvalid` high for one cycle, with `rdata` taken from the result register and `rerr = err`.
  - The other requester's outputs stay at 0.
  - Go to IDLE.
- **Width rule:** the result is exactly `mul_result`, the product modulo 2^`WIDTH`. The arbiter does no arithmetic of its own.
- **Request sampling:** requests are sampled only in IDLE. A request that rises during START, WAIT or RESP waits its turn.
- **Fairness:** with both requesters continuously requesting, grants strictly alternate.

**Reset** (asynchronous on `rst` low; outputs go to 0 without waiting for a clock edge):
- State goes to IDLE.
- `last = 1`, so requester 0 wins the first tie.
- `mul_a`, `mul_b`, the result register, the counter, `err` and `owner` clear to 0.
- Every output is 0.
- A reset during START or WAIT abandons the operation: no `rvalid` is issued for it.

## Timing

- Grant in cycle T (IDLE, request seen).
- `mul_start` high in T+1.
- WAIT begins at T+2; the earliest accepted `done` is at T+3.
- If `done` is accepted in cycle D, `rvalid` is high in D+1. The arbiter is back in IDLE at D+2, and a new grant is possible in D+2.
- Timeout: with no `done`, `rvalid` with `rerr = 1` appears at T+2+`TIMEOUT`.
- `busy` is high from T+1 through D+1 inclusive.

## Test plan

- **Single request:** `req0` with `a0=5`, `b0=3` -> `gnt0` pulse; `mul_start` one cycle later with `mul_a=5`, `mul_b=3`; `rvalid0` with `rdata0=15`, `rerr0=0`. `rvalid1` stays 0 throughout.
- **Simultaneous requests after reset:** `req0` (12×10) and `req1` (255×2) held high -> requester 0 served first with `rdata0=120`; `req1` granted in the cycle after `rvalid0` returns the arbiter to IDLE, giving `rdata1=254`. A third round, with both requesting again, grants requester 0 again (alternation).
- **Zero operand and back-to-back:** `req1` with 0×50, then immediately 7×9 -> `rdata1=0`, then `rdata1=63`. The second grant is in the cycle after the first `rvalid1` (the D+2 IDLE cycle).
- **Stale done:** multiplier stub holding `mul_done=1` across `start` for one cycle -> that first-WAIT-cycle `done` is ignored, and the correct product is returned.
- **Timeout:** stub that never asserts `mul_done`, `TIMEOUT=32` -> `rvalid0` with `rerr0=1` and `rdata0=0` at T+34. A following request completes normally.
- **Reset mid-operation:** assert `rst` low during WAIT -> all outputs 0 immediately, and no `rvalid` for the abandoned operation. After release, a `req0`/`req1` tie grants requester 0.
